tea_iter_encryptor: RTL

Iterative TEA block encryptor. It performs one full TEA cycle per clock, so a 64-bit block takes ROUNDS clocks.
- Area-lean counterpart to the team's pipelined decryptor: produces ciphertext that the decryptor restores to plaintext.
- Uses a valid/ready handshake on both input and output, plus a clock-enable for system-level stalling.

---
 rtl/tea_iter_encryptor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tea_iter_encryptor.sv
// Iterative TEA block encryptor: one full TEA cycle (both half-rounds) per enabled clock.
// Latency: accept edge A, ciphertext and out_valid visible after edge A+ROUNDS.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; ena=0 freezes all.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   ena               clock enable; 0 holds every register and blocks both handshakes
//   in_valid/in_ready input handshake carrying in_block (v0=[63:32], v1=[31:0]) and in_key
//   out_valid/out_ready output handshake carrying out_block = {v0,v1} ciphertext
//   busy              high while rounds are being computed
module tea_iter_encryptor #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Round counter value on the edge that completes the final cycle.
  localparam logic [7:0] LAST_CNT = 8'(ROUNDS - 1);

  state_t       r_state;
  state_t       w_next_state;
  logic [7:0]   r_cnt;
  logic [31:0]  r_sum;
  logic [31:0]  r_v0;
  logic [31:0]  r_v1;
  logic [127:0] r_key;
  logic [63:0]  r_out_block;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_sum_nx;
  logic [31:0]  w_v0_nx;
  logic [31:0]  w_v1_nx;
  logic         w_last;

  assign w_k0 = r_key[127:96];
  assign w_k1 = r_key[95:64];
  assign w_k2 = r_key[63:32];
  assign w_k3 = r_key[31:0];

  // One full TEA cycle; the v1 half consumes the freshly computed v0.
  assign w_sum_nx = r_sum + DELTA;
  assign w_v0_nx  = r_v0 + (((r_v1 << 4) + w_k0) ^ (r_v1 + w_sum_nx) ^ ((r_v1 >> 5) + w_k1));
  assign w_v1_nx  = r_v1 + (((w_v0_nx << 4) + w_k2) ^ (w_v0_nx + w_sum_nx) ^ ((w_v0_nx >> 5) + w_k3));
  assign w_last   = (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_block = r_out_block;

  // Datapath. out_block has its own register so it keeps the last ciphertext
  // after the handshake while v0/v1 are reloaded for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_sum       <= 32'd0;
      r_v0        <= 32'd0;
      r_v1        <= 32'd0;
      r_key       <= 128'd0;
      r_out_block <= 64'd0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_v0  <= in_block[63:32];
            r_v1  <= in_block[31:0];
            r_key <= in_key;
            r_sum <= 32'd0;
            r_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          r_v0  <= w_v0_nx;
          r_v1  <= w_v1_nx;
          r_sum <= w_sum_nx;
          r_cnt <= r_cnt + 8'd1;
          if (w_last) begin
            r_out_block <= {w_v0_nx, w_v1_nx};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
